pixel_fill_engine: RTL

- Write-side counterpart of the pixel plane renderer: fills axis-aligned rectangles of one 8-bit RRRGGGBB colour into the 320x240 pixel-plane VRAM.
- Sits between the CPU/MMIO command registers and the VRAM write port, which is arbitrated against CPU writes.
- Uses the same linear addressing as the renderer: addr = y*320 + x.

---
 rtl/gpu_pkg.sv | 17 +
 rtl/pixel_fill_engine_if.sv | 33 +++
 rtl/rect_clip.sv | 31 +++
 rtl/pixel_fill_engine.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared pixel-plane constants and types for the renderer and the fill engine.
package gpu_pkg;

  localparam int unsigned H_RES        = 320;
  localparam int unsigned V_RES        = 240;
  localparam int unsigned PIXEL_ADDR_W = 17;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    FILL,
    DONE
  } fill_state_t;

  typedef logic [7:0] pixel_colour_t;

endpackage

// File: rtl/pixel_fill_engine_if.sv
// Command and VRAM write-port bundle of the fill engine.
interface pixel_fill_engine_if #(
  parameter int unsigned ADDR_W = gpu_pkg::PIXEL_ADDR_W
);
  import gpu_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [8:0]        cmd_x;
  logic [7:0]        cmd_y;
  logic [8:0]        cmd_w;
  logic [7:0]        cmd_h;
  pixel_colour_t     cmd_color;
  logic [ADDR_W-1:0] vram_addr;
  pixel_colour_t     vram_d;
  logic              vram_we;
  logic              vram_ready;
  logic              busy;
  logic              done;

  // Engine side: consumes commands, drives the VRAM write port.
  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, vram_ready,
    output cmd_ready, vram_addr, vram_d, vram_we, busy, done
  );

  // Command source / arbiter side.
  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, vram_ready,
    input  cmd_ready, vram_addr, vram_d, vram_we, busy, done
  );

endinterface

// File: rtl/rect_clip.sv
// Clips a rectangle to the 320x240 plane and computes its first-row address.
module rect_clip
  import gpu_pkg::*;
#(
  parameter int unsigned ADDR_W = PIXEL_ADDR_W
) (
  input  logic [8:0]        x_i,
  input  logic [7:0]        y_i,
  input  logic [8:0]        w_i,
  input  logic [7:0]        h_i,
  output logic              empty_o,
  output logic [9:0]        eff_w_o,
  output logic [9:0]        eff_h_o,
  output logic [ADDR_W-1:0] row_base_o
);

  logic [9:0] rem_w;
  logic [9:0] rem_h;

  // Clip width/height at 10 bits; row base uses y*320 = (y<<8)+(y<<6).
  always_comb begin
    empty_o    = ({1'b0, x_i} >= 10'(H_RES)) || ({2'b00, y_i} >= 10'(V_RES)) ||
                 (w_i == '0) || (h_i == '0);
    rem_w      = 10'(H_RES) - {1'b0, x_i};
    rem_h      = 10'(V_RES) - {2'b00, y_i};
    eff_w_o    = ({1'b0, w_i} < rem_w) ? {1'b0, w_i} : rem_w;
    eff_h_o    = ({2'b00, h_i} < rem_h) ? {2'b00, h_i} : rem_h;
    row_base_o = (ADDR_W'(y_i) << 8) + (ADDR_W'(y_i) << 6) + ADDR_W'(x_i);
  end

endmodule

// File: rtl/pixel_fill_engine.sv
// Fills a clipped rectangle of one colour into pixel-plane VRAM, one pixel per granted cycle.
module pixel_fill_engine
  import gpu_pkg::*;
#(
  parameter int unsigned ADDR_W = PIXEL_ADDR_W
) (
  input  logic                clk,
  input  logic                reset,
  pixel_fill_engine_if.slave  bus
);

  fill_state_t       state_q, state_d;
  logic [8:0]        x_q, x_d;
  logic [7:0]        y_q, y_d;
  logic [8:0]        w_q, w_d;
  logic [7:0]        h_q, h_d;
  pixel_colour_t     colour_q, colour_d;
  logic [9:0]        eff_w_q, eff_w_d;
  logic [9:0]        eff_h_q, eff_h_d;
  logic [9:0]        col_q, col_d;
  logic [9:0]        row_q, row_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              clip_empty;
  logic [9:0]        clip_eff_w;
  logic [9:0]        clip_eff_h;
  logic [ADDR_W-1:0] clip_row_base;

  rect_clip #(.ADDR_W(ADDR_W)) u_clip (
    .x_i        (x_q),
    .y_i        (y_q),
    .w_i        (w_q),
    .h_i        (h_q),
    .empty_o    (clip_empty),
    .eff_w_o    (clip_eff_w),
    .eff_h_o    (clip_eff_h),
    .row_base_o (clip_row_base)
  );

  // Next-state and datapath: latch command, clip, then walk columns and rows.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    w_d        = w_q;
    h_d        = h_q;
    colour_d   = colour_q;
    eff_w_d    = eff_w_q;
    eff_h_d    = eff_h_q;
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          x_d      = bus.cmd_x;
          y_d      = bus.cmd_y;
          w_d      = bus.cmd_w;
          h_d      = bus.cmd_h;
          colour_d = bus.cmd_color;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        if (clip_empty) begin
          state_d = DONE;
        end else begin
          eff_w_d    = clip_eff_w;
          eff_h_d    = clip_eff_h;
          col_d      = '0;
          row_d      = '0;
          row_base_d = clip_row_base;
          addr_d     = clip_row_base;
          state_d    = FILL;
        end
      end
      FILL: begin
        if (bus.vram_ready) begin
          if (col_q != eff_w_q - 10'd1) begin
            col_d  = col_q + 10'd1;
            addr_d = addr_q + ADDR_W'(1);
          end else if (row_q != eff_h_q - 10'd1) begin
            col_d      = '0;
            row_d      = row_q + 10'd1;
            row_base_d = row_base_q + ADDR_W'(H_RES);
            addr_d     = row_base_q + ADDR_W'(H_RES);
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any fill in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      w_q        <= '0;
      h_q        <= '0;
      colour_q   <= '0;
      eff_w_q    <= '0;
      eff_h_q    <= '0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      w_q        <= w_d;
      h_q        <= h_d;
      colour_q   <= colour_d;
      eff_w_q    <= eff_w_d;
      eff_h_q    <= eff_h_d;
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.vram_we   = (state_q == FILL);
  assign bus.vram_addr = addr_q;
  assign bus.vram_d    = colour_q;

endmodule
